// File: rtl/spi_sram_target.sv
// rtl/spi_sram_target.sv - serial SRAM responder (SPI/QPI) for the spi_sram controller link
//
// Oversampled in the clk domain: cs_pin, sck_pin and sio_in are synchronized,
// sck edges are detected, and a single FSM decodes opcode/address/data.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   cs_pin    chip select, active-low
//   sck_pin   serial clock, mode 0 (sample on rise, shift out on fall)
//   sio_in    pad inputs; SPI uses sio_in[0] as MOSI
//   sio_out   pad output data; SPI uses sio_out[1] as MISO
//   sio_oe    per-pin output enable, 1 = drive
//   quad_mode 1 = QPI active
//   busy      cs low and a transaction in progress
//   cmd_err   one-cycle pulse on an unknown opcode
//
// Optional feature macro: SRAM_RDMR_EN (opcode 8'h05 returns mode register 8'h40).
module spi_sram_target #(
    parameter int         SRAM_ADDR_WIDTH = 16,
    parameter int         ADDR_BYTES      = 2,
    parameter int         DUMMY_BYTES     = 1,
    parameter logic [7:0] CMD_READ        = 8'h03,
    parameter logic [7:0] CMD_WRITE       = 8'h02,
    parameter logic [7:0] CMD_EQIO        = 8'h38,
    parameter logic [7:0] CMD_RSTIO       = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_pin,
    input  logic       sck_pin,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe,
    output logic       quad_mode,
    output logic       busy,
    output logic       cmd_err
);
    localparam int ADDR_BITS = ADDR_BYTES * 8;
    localparam logic [15:0] ADDR_END  = 16'(ADDR_BITS);
    localparam logic [15:0] DUMMY_END = 16'(DUMMY_BYTES * 8);
    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
    state_t state;

    // Synchronizers; cs idles high so reset must not look like a select.
    logic [1:0] cs_sync, sck_sync;
    logic [3:0] sio_m, sio_s;
    logic       sck_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= 2'b11;
            sck_sync <= 2'b00;
            sio_m    <= 4'h0;
            sio_s    <= 4'h0;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[0], cs_pin};
            sck_sync <= {sck_sync[0], sck_pin};
            sio_m    <= sio_in;
            sio_s    <= sio_m;
            sck_d    <= sck_sync[1];
        end
    end

    logic cs_s, sck_rise, sck_fall;
    assign cs_s     = cs_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;

    logic [15:0]                cnt;
    logic [7:0]                 sr;
    logic [ADDR_BITS-1:0]       addr_sh;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic                       is_read, load, wr_pend, rdmr;
    logic [7:0]                 wr_byte, out_byte, osh;
    logic [3:0]                 ocnt;

    logic [15:0]          step, cnt_next;
    logic [3:0]           ostep, ocnt_next, oe_val;
    logic [7:0]           sr_next, cur_byte;
    logic [ADDR_BITS-1:0] addr_next;

    assign step      = quad_mode ? 16'd4 : 16'd1;
    assign ostep     = quad_mode ? 4'd4 : 4'd1;
    assign cnt_next  = cnt + step;
    assign ocnt_next = ocnt + ostep;
    assign oe_val    = quad_mode ? 4'b1111 : 4'b0010;
    assign sr_next   = quad_mode ? {sr[3:0], sio_s} : {sr[6:0], sio_s[0]};
    assign addr_next = quad_mode ? {addr_sh[ADDR_BITS-5:0], sio_s}
                                 : {addr_sh[ADDR_BITS-2:0], sio_s[0]};
    // At a byte boundary the next byte comes from the prefetch (or the
    // fixed mode register value); otherwise continue the shift register.
    assign cur_byte  = (ocnt != 4'd0) ? osh : (rdmr ? 8'h40 : out_byte);

    assign busy = ~cs_s & (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            quad_mode <= 1'b0;
            sio_out   <= 4'h0;
            sio_oe    <= 4'h0;
            cmd_err   <= 1'b0;
            cnt       <= 16'd0;
            sr        <= 8'h00;
            addr_sh   <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            load      <= 1'b0;
            wr_pend   <= 1'b0;
            wr_byte   <= 8'h00;
            rdmr      <= 1'b0;
            osh       <= 8'h00;
            ocnt      <= 4'd0;
        end else begin
            cmd_err <= 1'b0;
            load    <= 1'b0;
            wr_pend <= 1'b0;
            // Address advances right after each memory access (read prefetch or write).
            if (wr_pend || load) addr <= addr + ADDR_ONE;
            if (cs_s) begin
                state   <= IDLE;
                sio_oe  <= 4'h0;
                sio_out <= 4'h0;
                cnt     <= 16'd0;
                sr      <= 8'h00;
                ocnt    <= 4'd0;
                rdmr    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                        cnt   <= 16'd0;
                    end
                    CMD: if (sck_rise) begin
                        sr <= sr_next;
                        if (cnt_next == 16'd8) begin
                            cnt <= 16'd0;
                            if (sr_next == CMD_READ) begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end else if (sr_next == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ADDR;
                            end else if (sr_next == CMD_EQIO && !quad_mode) begin
                                quad_mode <= 1'b1;
                                state     <= IGNORE;
                            end else if (sr_next == CMD_RSTIO && quad_mode) begin
                                quad_mode <= 1'b0;
                                state     <= IGNORE;
`ifdef SRAM_RDMR_EN
                            end else if (sr_next == 8'h05) begin
                                rdmr   <= 1'b1;
                                state  <= RDATA;
                                sio_oe <= oe_val;
`endif
                            end else begin
                                cmd_err <= 1'b1;
                                state   <= IGNORE;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_sh <= addr_next;
                        if (cnt_next == ADDR_END) begin
                            cnt  <= 16'd0;
                            addr <= addr_next[SRAM_ADDR_WIDTH-1:0];
                            if (is_read) begin
                                load <= 1'b1;
                                if (quad_mode && DUMMY_BYTES > 0) begin
                                    state <= DUMMY;
                                end else begin
                                    state  <= RDATA;
                                    sio_oe <= oe_val;
                                end
                            end else begin
                                state <= WDATA;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    DUMMY: if (sck_rise) begin
                        if (cnt_next == DUMMY_END) begin
                            cnt    <= 16'd0;
                            state  <= RDATA;
                            sio_oe <= oe_val;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    RDATA: if (sck_fall) begin
                        sio_out <= quad_mode ? cur_byte[7:4] : {2'b00, cur_byte[7], 1'b0};
                        osh     <= quad_mode ? {cur_byte[3:0], 4'h0} : {cur_byte[6:0], 1'b0};
                        if (ocnt_next == 4'd8) begin
                            ocnt <= 4'd0;
                            load <= ~rdmr;
                        end else begin
                            ocnt <= ocnt_next;
                        end
                    end
                    WDATA: if (sck_rise) begin
                        sr <= sr_next;
                        if (cnt_next == 16'd8) begin
                            cnt     <= 16'd0;
                            wr_byte <= sr_next;
                            wr_pend <= 1'b1;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Memory array kept out of the reset domain; contents are undefined after reset.
    logic [7:0] mem [0:(1<<SRAM_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_pend) mem[addr] <= wr_byte;
        if (load) out_byte <= mem[addr];
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb/tb_spi_sram_target.sv - self-checking bench for spi_sram_target
module tb_spi_sram_target;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_pin = 1'b1;
    logic       sck_pin = 1'b0;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out, sio_oe;
    logic       quad_mode, busy, cmd_err;

    always #5 clk = ~clk;

    spi_sram_target dut (
        .clk      (clk),
        .rst      (rst),
        .cs_pin   (cs_pin),
        .sck_pin  (sck_pin),
        .sio_in   (sio_in),
        .sio_out  (sio_out),
        .sio_oe   (sio_oe),
        .quad_mode(quad_mode),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    typedef struct {
        int          phase;
        logic        wr;
        logic [15:0] addr;
        int          n;
        logic [23:0] d;
    } vec_t;

    vec_t        vecs [16];
    int          nvecs = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [0:65535];
    logic [7:0]  exp_q [$];
    logic        quad_tb = 1'b0;
    logic [3:0]  oe_last = 4'h0;

    int   err_cycles = 0, err_pulses = 0, oe_cycles = 0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (cmd_err) err_cycles <= err_cycles + 1;
        if (cmd_err && !err_prev) err_pulses <= err_pulses + 1;
        if (sio_oe != 4'h0) oe_cycles <= oe_cycles + 1;
        err_prev <= cmd_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_unit(input logic [3:0] d, output logic [3:0] q);
        sio_in = quad_tb ? d : {3'b000, d[0]};
        wait_clks(HALF);
        q = quad_tb ? sio_out : {3'b000, sio_out[1]};
        oe_last = sio_oe;
        sck_pin = 1'b1;
        wait_clks(HALF);
        sck_pin = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
        logic [3:0] q;
        r = 8'h00;
        if (quad_tb) begin
            shift_unit(b[7:4], q);
            r[7:4] = q;
            shift_unit(b[3:0], q);
            r[3:0] = q;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                shift_unit({3'b000, b[i]}, q);
                r[i] = q[0];
            end
        end
    endtask

    task automatic cs_low();
        cs_pin = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(2);
        cs_pin = 1'b1;
        wait_clks(6);
    endtask

    task automatic one_cmd(input logic [7:0] op);
        logic [7:0] r;
        cs_low();
        send_byte(op, r);
        cs_high();
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0]  r, e;
        logic [15:0] a;
        logic [3:0]  exp_oe;
        exp_oe = quad_tb ? 4'hF : 4'h2;
        if (!v.wr) begin
            for (int i = 0; i < v.n; i++) begin
                a = v.addr + 16'(i);
                exp_q.push_back(model[a]);
            end
        end
        cs_low();
        send_byte(v.wr ? 8'h02 : 8'h03, r);
        send_byte(v.addr[15:8], r);
        send_byte(v.addr[7:0], r);
        check("oe_during_cmd", oe_last, 4'h0);
        if (v.wr) begin
            for (int i = 0; i < v.n; i++) begin
                a = v.addr + 16'(i);
                send_byte(v.d[23-8*i -: 8], r);
                model[a] = v.d[23-8*i -: 8];
            end
        end else begin
            if (quad_tb) send_byte(8'h00, r);
            for (int i = 0; i < v.n; i++) begin
                send_byte(8'h00, r);
                e = exp_q.pop_front();
                check("rdata", r, e);
                check("rdata_oe", oe_last, exp_oe);
            end
        end
        check("busy_active", busy, 1);
        cs_high();
        check("oe_after_cs", sio_oe, 4'h0);
        check("busy_after_cs", busy, 0);
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < nvecs; i++)
            if (vecs[i].phase == p) run_vec(vecs[i]);
    endtask

    task automatic add_vec(input int p, input logic wr, input logic [15:0] a, input int n,
                           input logic [23:0] d);
        vecs[nvecs] = '{phase: p, wr: wr, addr: a, n: n, d: d};
        nvecs++;
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] q;
        int c0, p0, o0;

        add_vec(0, 1'b1, 16'h5678, 1, 24'h9A0000);
        add_vec(0, 1'b0, 16'h5678, 1, 24'h0);
        add_vec(1, 1'b1, 16'h1234, 2, 24'hABCD00);
        add_vec(1, 1'b0, 16'h1234, 2, 24'h0);
        add_vec(1, 1'b1, 16'hFFFF, 3, 24'h010203);
        add_vec(1, 1'b0, 16'hFFFF, 1, 24'h0);
        add_vec(1, 1'b0, 16'h0000, 1, 24'h0);
        add_vec(1, 1'b0, 16'h0001, 1, 24'h0);
        add_vec(1, 1'b0, 16'hFFFF, 3, 24'h0);
        add_vec(1, 1'b1, 16'h0010, 2, 24'hEE5A00);
        add_vec(2, 1'b0, 16'h1234, 1, 24'h0);
        add_vec(2, 1'b0, 16'h0010, 2, 24'h0);
        add_vec(3, 1'b1, 16'h0000, 1, 24'h110000);
        add_vec(3, 1'b0, 16'h0000, 1, 24'h0);

        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        check("rst_sio_out", sio_out, 4'h0);
        check("rst_sio_oe", sio_oe, 4'h0);
        check("rst_quad", quad_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);

        // SPI write then read
        run_phase(0);

        // Enter QPI
        one_cmd(8'h38);
        quad_tb = 1'b1;
        check("eqio_quad", quad_mode, 1);
        run_phase(1);

        // Abort: 1.5 bytes written at 0010, only the full byte lands
        cs_low();
        send_byte(8'h02, r);
        send_byte(8'h00, r);
        send_byte(8'h10, r);
        send_byte(8'h77, r);
        shift_unit(4'h3, q);
        cs_high();
        model[16'h0010] = 8'h77;

        // Unknown opcode
        c0 = err_cycles;
        p0 = err_pulses;
        o0 = oe_cycles;
        one_cmd(8'hA5);
        check("err_cycles", err_cycles - c0, 1);
        check("err_pulses", err_pulses - p0, 1);
        check("err_no_oe", oe_cycles - o0, 0);
        check("err_keeps_quad", quad_mode, 1);

        // Back to SPI
        one_cmd(8'hFF);
        quad_tb = 1'b0;
        check("rstio_quad", quad_mode, 0);
        run_phase(2);

        // Reset during a QPI write
        one_cmd(8'h38);
        quad_tb = 1'b1;
        check("eqio2_quad", quad_mode, 1);
        cs_low();
        send_byte(8'h02, r);
        send_byte(8'h00, r);
        send_byte(8'h00, r);
        shift_unit(4'h5, q);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        cs_pin = 1'b1;
        wait_clks(2);
        check("midrst_quad", quad_mode, 0);
        check("midrst_oe", sio_oe, 4'h0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        quad_tb = 1'b0;
        wait_clks(4);
        run_phase(3);

        check("total_err_pulses", err_pulses, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
